// File: rtl/bcd_counter_multidigit_if.sv
// Pulse/direction/clear inputs and count/display outputs of the multi-digit BCD counter.
// slave is the counter side, master is the side that drives events and watches the display.
interface bcd_counter_multidigit_if #(
    parameter int DIGITS = 4
);
    logic                  pulse;
    logic                  up_down;
    logic                  clear;
    logic [4*DIGITS-1:0]   count_bcd;
    logic                  carry;
    logic [7:0]            seven_segment_data;
    logic [DIGITS-1:0]     seven_segment_enable;

    modport master (
        output pulse, up_down, clear,
        input  count_bcd, carry, seven_segment_data, seven_segment_enable
    );

    modport slave (
        input  pulse, up_down, clear,
        output count_bcd, carry, seven_segment_data, seven_segment_enable
    );
endinterface

// File: rtl/bcd_counter_multidigit.sv
// Multi-digit BCD up/down event counter with a time-multiplexed active-low 7-segment scan.
// Count/carry register 1 cycle after a pulse rising edge; display registers trail count/idx by 1 cycle; no backpressure.
module bcd_counter_multidigit #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 100000
) (
    input  logic                          clk,
    input  logic                          rst,
    bcd_counter_multidigit_if.slave       bus
);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    logic                      pulse_q;
    logic                      step;
    logic [DIGITS-1:0][3:0]    count_q, count_d;
    logic                      carry_q, carry_d;
    logic                      prop;
    logic [SCAN_W-1:0]         scan_q, scan_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [3:0]                digit_sel;
    logic [7:0]                seg_q, seg_d;
    logic [DIGITS-1:0]         en_q, en_d;

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 8'hC0;
            4'd1:    seg_decode = 8'hF9;
            4'd2:    seg_decode = 8'hA4;
            4'd3:    seg_decode = 8'hB0;
            4'd4:    seg_decode = 8'h99;
            4'd5:    seg_decode = 8'h92;
            4'd6:    seg_decode = 8'h82;
            4'd7:    seg_decode = 8'hF8;
            4'd8:    seg_decode = 8'h80;
            4'd9:    seg_decode = 8'h90;
            default: seg_decode = 8'hFF;
        endcase
    endfunction

    assign step = bus.pulse & ~pulse_q;

    // Ripple increment/borrow: prop stays high while every lower digit wrapped.
    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        prop    = 1'b1;
        if (bus.clear) begin
            count_d = '0;
        end else if (step) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (prop) begin
                    if (bus.up_down) begin
                        if (count_q[i] == 4'd9) begin
                            count_d[i] = 4'd0;
                        end else begin
                            count_d[i] = count_q[i] + 4'd1;
                            prop       = 1'b0;
                        end
                    end else begin
                        if (count_q[i] == 4'd0) begin
                            count_d[i] = 4'd9;
                        end else begin
                            count_d[i] = count_q[i] - 4'd1;
                            prop       = 1'b0;
                        end
                    end
                end
            end
            carry_d = prop;
        end
    end

    always_comb begin
        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        digit_sel = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                digit_sel = count_q[i];
            end
        end
        seg_d = seg_decode(digit_sel);
        en_d  = ~(DIGITS'(1) << idx_q);
    end

    // pulse_q resets high so a pulse held across reset release is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q <= 1'b1;
            count_q <= '0;
            carry_q <= 1'b0;
            scan_q  <= '0;
            idx_q   <= '0;
            seg_q   <= 8'hC0;
            en_q    <= ~DIGITS'(1);
        end else begin
            pulse_q <= bus.pulse;
            count_q <= count_d;
            carry_q <= carry_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            en_q    <= en_d;
        end
    end

    assign bus.count_bcd            = count_q;
    assign bus.carry                = carry_q;
    assign bus.seven_segment_data   = seg_q;
    assign bus.seven_segment_enable = en_q;
endmodule

// File: tb/tb_bcd_counter_multidigit.sv
// Directed bench for a 2-digit counter with a 4-cycle scan dwell; a decimal reference model
// queues the expected registered outputs for every cycle and constant checks cover the plan's landmarks.
module tb_bcd_counter_multidigit;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bcd_counter_multidigit_if #(.DIGITS(2)) bus ();

    bcd_counter_multidigit #(
        .DIGITS   (2),
        .SCAN_DIV (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [7:0] cnt;
        logic       carry;
        logic [7:0] seg;
        logic [1:0] en;
    } exp_t;

    exp_t exp_q[$];

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: count as a plain decimal number 0..99.
    int   m_cnt  = 0;
    logic m_pq   = 1'b1;
    int   m_scan = 0;
    int   m_idx  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_total++;
        assert (obs === req) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, req);
    endtask

    task automatic cyc(input logic r, input logic p, input logic ud, input logic c);
        exp_t e;
        exp_t got;
        rst         = r;
        bus.pulse   = p;
        bus.up_down = ud;
        bus.clear   = c;
        e.carry = 1'b0;
        if (r) begin
            m_cnt  = 0;
            m_pq   = 1'b1;
            m_scan = 0;
            m_idx  = 0;
            e.seg  = 8'hC0;
            e.en   = 2'b10;
        end else begin
            e.seg = seg_tab[(m_idx == 0) ? (m_cnt % 10) : (m_cnt / 10)];
            e.en  = (m_idx == 0) ? 2'b10 : 2'b01;
            if (c) begin
                m_cnt = 0;
            end else if (p && !m_pq) begin
                if (ud) begin
                    if (m_cnt == 99) begin m_cnt = 0; e.carry = 1'b1; end
                    else m_cnt = m_cnt + 1;
                end else begin
                    if (m_cnt == 0) begin m_cnt = 99; e.carry = 1'b1; end
                    else m_cnt = m_cnt - 1;
                end
            end
            m_pq = p;
            if (m_scan == 3) begin
                m_scan = 0;
                m_idx  = 1 - m_idx;
            end else begin
                m_scan = m_scan + 1;
            end
        end
        e.cnt = {4'(m_cnt / 10), 4'(m_cnt % 10)};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk("count_bcd", {24'd0, bus.count_bcd}, {24'd0, got.cnt});
        chk("carry", {31'd0, bus.carry}, {31'd0, got.carry});
        chk("seg_data", {24'd0, bus.seven_segment_data}, {24'd0, got.seg});
        chk("seg_enable", {30'd0, bus.seven_segment_enable}, {30'd0, got.en});
    endtask

    task automatic pulse_once(input logic ud);
        cyc(1'b0, 1'b1, ud, 1'b0);
        cyc(1'b0, 1'b0, ud, 1'b0);
    endtask

    initial begin
        int ncarry;
        int guard;

        // Reset and idle: enable toggles every 4 cycles, data stays C0.
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("reset_count", {24'd0, bus.count_bcd}, 32'h00);
        chk("reset_seg", {24'd0, bus.seven_segment_data}, 32'hC0);
        chk("reset_en", {30'd0, bus.seven_segment_enable}, 32'h2);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("idle_count", {24'd0, bus.count_bcd}, 32'h00);
        chk("idle_carry", {31'd0, bus.carry}, 32'h0);

        // Twelve up pulses, then both digits on the scan.
        for (int i = 0; i < 12; i++) pulse_once(1'b1);
        chk("up12_count", {24'd0, bus.count_bcd}, 32'h12);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            if (bus.seven_segment_enable == 2'b10)
                chk("up12_digit0", {24'd0, bus.seven_segment_data}, 32'hA4);
            else
                chk("up12_digit1", {24'd0, bus.seven_segment_data}, 32'hF9);
        end

        // Up to 99, then wrap with the pulse held for 5 cycles.
        for (int i = 0; i < 87; i++) pulse_once(1'b1);
        chk("up99_count", {24'd0, bus.count_bcd}, 32'h99);
        ncarry = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0);
            if (i == 0) chk("wrap_first_carry", {31'd0, bus.carry}, 32'h1);
            ncarry += int'(bus.carry);
        end
        chk("wrap_carry_cycles", ncarry, 32'd1);
        chk("wrap_held_count", {24'd0, bus.count_bcd}, 32'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Down from 00 borrows to 99, then 98.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("down_wrap_count", {24'd0, bus.count_bcd}, 32'h99);
        chk("down_wrap_carry", {31'd0, bus.carry}, 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("down_carry_drop", {31'd0, bus.carry}, 32'h0);
        pulse_once(1'b0);
        chk("down_98", {24'd0, bus.count_bcd}, 32'h98);

        // Reach 45, then clear together with a rising pulse.
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 45; i++) pulse_once(1'b1);
        chk("pre_clear_count", {24'd0, bus.count_bcd}, 32'h45);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        chk("clear_count", {24'd0, bus.count_bcd}, 32'h00);
        chk("clear_carry", {31'd0, bus.carry}, 32'h0);

        // Reset with the pulse high, released while still high: no step.
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("rst_held_pulse", {24'd0, bus.count_bcd}, 32'h00);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Rising edge on the edge where scan_cnt wraps from 3.
        guard = 0;
        while (m_scan != 3 && guard < 8) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            guard++;
        end
        chk("scan_align_bound", {31'd0, guard < 8}, 32'h1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("boundary_count", {24'd0, bus.count_bcd}, 32'h01);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
